// File: rtl/vec_vsetvl_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vec_vsetvl_unit
//  Description : Executes vsetvli / vsetivli / vsetvl. Validates the requested
//                vtype, computes VLMAX and the new vl, strobes the vector CSR
//                file for one cycle and returns the new vl for rd writeback.
//                Optional feature macro: VEC_FRACTIONAL_LMUL_EN (enables the
//                fractional LMUL codes mf8/mf4/mf2).
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_vsetvl_unit #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 64
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [1:0]      vset_kind,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [10:0]     zimm,
    input  logic [4:0]      uimm,
    input  logic            rs1_is_x0,
    input  logic            rd_is_x0,
    input  logic [XLEN-1:0] cur_vl,
    output logic            csrwr_en,
    output logic [XLEN-1:0] vtype_o,
    output logic [XLEN-1:0] vl_o,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_data
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_DECODE = 2'd1;
    localparam logic [1:0] C_ST_COMMIT = 2'd2;
    localparam logic [1:0] C_ST_RESP   = 2'd3;

    localparam logic [1:0] C_KIND_VSETVLI  = 2'b00;
    localparam logic [1:0] C_KIND_VSETIVLI = 2'b01;
    localparam logic [1:0] C_KIND_VSETVL   = 2'b10;
    localparam logic [1:0] C_KIND_RSVD     = 2'b11;

    localparam logic [XLEN-1:0] C_VLEN    = XLEN'(VLEN);
    localparam logic [XLEN-1:0] C_ELEN    = XLEN'(ELEN);
    localparam logic [XLEN-1:0] C_SEW_MIN = XLEN'(8);
    localparam logic [XLEN-1:0] C_VILL    = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------------
    // State and captured instruction fields
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      r_kind;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [10:0]     r_zimm;
    logic [4:0]      r_uimm;
    logic            r_rs1_x0;
    logic            r_rd_x0;
    logic [XLEN-1:0] r_cur_vl;
    logic [XLEN-1:0] r_vtype;
    logic [XLEN-1:0] r_vl;
    logic [XLEN-1:0] r_rd_data;

    // ------------------------------------------------------------------------
    // Decode-stage combinational signals
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_raw;
    logic [2:0]      w_vsew;
    logic [2:0]      w_vlmul;
    logic            w_base_ok;
    logic [XLEN-1:0] w_sew_bits;
    logic [XLEN-1:0] w_vlen_per_sew;
    logic [XLEN-1:0] w_vlmax_int;
    logic            w_sew_ok_int;
    logic            w_legal;
    logic [XLEN-1:0] w_vlmax;
    logic [XLEN-1:0] w_avl;
    logic [XLEN-1:0] w_vl_new;
    logic [XLEN-1:0] w_vtype_new;
    logic            w_unused;

`ifdef VEC_FRACTIONAL_LMUL_EN
    logic [2:0]      w_frac_sh;
    logic [XLEN-1:0] w_vlmax_frac;
    logic            w_sew_ok_frac;
`endif

    // Handshake and strobe outputs are pure functions of the state
    assign inst_ready = (r_state == C_ST_IDLE);
    assign csrwr_en   = (r_state == C_ST_COMMIT);
    assign rd_valid   = (r_state == C_ST_RESP);
    assign vtype_o    = r_vtype;
    assign vl_o       = r_vl;
    assign rd_data    = r_rd_data;

    // Select the raw vtype source for the captured instruction kind
    always_comb begin
        w_raw = '0;
        case (r_kind)
            C_KIND_VSETVLI:  w_raw = {{(XLEN-11){1'b0}}, r_zimm};
            C_KIND_VSETIVLI: w_raw = {{(XLEN-10){1'b0}}, r_zimm[9:0]};
            C_KIND_VSETVL:   w_raw = r_rs2;
            default:         w_raw = '0;
        endcase
    end

    assign w_vsew  = w_raw[5:3];
    assign w_vlmul = w_raw[2:0];

    // The incoming vill bit of a vsetvl source carries no meaning here; the
    // result vill is recomputed from legality alone.
    assign w_unused = w_raw[XLEN-1];

    // Field checks shared by every LMUL encoding
    assign w_base_ok = (r_kind != C_KIND_RSVD)
                    && (w_raw[XLEN-2:8] == '0)
                    && (w_vsew <= 3'd3);

    // SEW in bits and VLEN/SEW; shift amount widened so vsew up to 7 is safe
    assign w_sew_bits     = C_SEW_MIN << w_vsew;
    assign w_vlen_per_sew = C_VLEN >> ({1'b0, w_vsew} + 4'd3);

    // Integer LMUL (1,2,4,8): VLMAX scales up, SEW must fit ELEN*LMUL
    assign w_vlmax_int  = w_vlen_per_sew << w_vlmul[1:0];
    assign w_sew_ok_int = (w_sew_bits <= (C_ELEN << w_vlmul[1:0]));

`ifdef VEC_FRACTIONAL_LMUL_EN
    // Fractional LMUL: 101->1/8, 110->1/4, 111->1/2, i.e. shift by (8-vlmul)
    assign w_frac_sh     = 3'd0 - w_vlmul;
    assign w_vlmax_frac  = w_vlen_per_sew >> w_frac_sh;
    assign w_sew_ok_frac = (w_sew_bits <= (C_ELEN >> w_frac_sh));
`endif

    // Overall legality and VLMAX for the selected LMUL encoding
    always_comb begin
        w_legal = 1'b0;
        w_vlmax = w_vlmax_int;
        if (!w_vlmul[2]) begin
            w_legal = w_base_ok && w_sew_ok_int;
        end
`ifdef VEC_FRACTIONAL_LMUL_EN
        else if (w_vlmul != 3'b100) begin
            w_legal = w_base_ok && w_sew_ok_frac;
            w_vlmax = w_vlmax_frac;
        end
`endif
    end

    // Application vector length selection
    always_comb begin
        w_avl = r_cur_vl;
        if (r_kind == C_KIND_VSETIVLI) begin
            w_avl = {{(XLEN-5){1'b0}}, r_uimm};
        end else if (!r_rs1_x0) begin
            w_avl = r_rs1;
        end else if (!r_rd_x0) begin
            w_avl = w_vlmax;
        end
    end

    // New vl/vtype: clamp AVL to VLMAX when legal, otherwise vill with vl=0
    always_comb begin
        w_vl_new    = '0;
        w_vtype_new = C_VILL;
        if (w_legal) begin
            w_vl_new    = (w_avl < w_vlmax) ? w_avl : w_vlmax;
            w_vtype_new = {{(XLEN-8){1'b0}}, w_raw[7:0]};
        end
    end

    // Control FSM, instruction capture and committed result registers.
    // Results are loaded on the DECODE->COMMIT edge so they are valid for the
    // whole COMMIT cycle and hold afterwards.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= C_ST_IDLE;
            r_kind    <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_zimm    <= '0;
            r_uimm    <= '0;
            r_rs1_x0  <= 1'b0;
            r_rd_x0   <= 1'b0;
            r_cur_vl  <= '0;
            r_vtype   <= C_VILL;
            r_vl      <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (inst_valid) begin
                        r_kind   <= vset_kind;
                        r_rs1    <= rs1_data;
                        r_rs2    <= rs2_data;
                        r_zimm   <= zimm;
                        r_uimm   <= uimm;
                        r_rs1_x0 <= rs1_is_x0;
                        r_rd_x0  <= rd_is_x0;
                        r_cur_vl <= cur_vl;
                        r_state  <= C_ST_DECODE;
                    end
                end
                C_ST_DECODE: begin
                    r_vtype   <= w_vtype_new;
                    r_vl      <= w_vl_new;
                    r_rd_data <= w_vl_new;
                    r_state   <= C_ST_COMMIT;
                end
                C_ST_COMMIT: begin
                    r_state <= r_rd_x0 ? C_ST_IDLE : C_ST_RESP;
                end
                C_ST_RESP: begin
                    if (rd_ready) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_vsetvl_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vec_vsetvl_unit
//  Description : Self-checking bench for vec_vsetvl_unit: directed cases and
//                randomized instructions against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_vsetvl_unit;

    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int ELEN = 64;
    localparam logic [31:0] VILL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [1:0]  vset_kind = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [10:0] zimm = '0;
    logic [4:0]  uimm = '0;
    logic        rs1_is_x0 = 1'b0;
    logic        rd_is_x0 = 1'b0;
    logic [31:0] cur_vl = '0;
    logic        csrwr_en;
    logic [31:0] vtype_o;
    logic [31:0] vl_o;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    vec_vsetvl_unit #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .vset_kind  (vset_kind),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .zimm       (zimm),
        .uimm       (uimm),
        .rs1_is_x0  (rs1_is_x0),
        .rd_is_x0   (rd_is_x0),
        .cur_vl     (cur_vl),
        .csrwr_en   (csrwr_en),
        .vtype_o    (vtype_o),
        .vl_o       (vl_o),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural rules with plain integer arithmetic
    task automatic model(input logic [1:0] kind, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [10:0] zi, input logic [4:0] ui, input logic r1x0,
                         input logic rdx0, input logic [31:0] cvl,
                         output logic [31:0] exp_vtype, output logic [31:0] exp_vl);
        logic [31:0] raw;
        logic [31:0] avl;
        int vsew, vlmul, sew, lmul, den;
        longint vlmax;
        bit legal;
        raw = 32'd0;
        if (kind == 2'd2) raw = rs2;
        else if (kind == 2'd0) raw = {21'd0, zi};
        else if (kind == 2'd1) raw = {22'd0, zi[9:0]};
        vsew  = int'(raw[5:3]);
        vlmul = int'(raw[2:0]);
        legal = (kind != 2'd3) && (raw[30:8] == 23'd0) && (vsew <= 3);
        sew   = 8 * (2 ** vsew);
        vlmax = 0;
        if (vlmul < 4) begin
            lmul  = 2 ** vlmul;
            vlmax = longint'(VLEN) * lmul / sew;
            if (sew > ELEN * lmul) legal = 0;
        end else if (vlmul == 4) begin
            legal = 0;
        end else begin
`ifdef VEC_FRACTIONAL_LMUL_EN
            den   = 2 ** (8 - vlmul);
            vlmax = longint'(VLEN) / (sew * den);
            if (sew * den > ELEN) legal = 0;
`else
            den   = 0;
            legal = 0;
`endif
        end
        if (kind == 2'd1)  avl = {27'd0, ui};
        else if (!r1x0)    avl = rs1;
        else if (!rdx0)    avl = 32'(vlmax);
        else               avl = cvl;
        if (legal) begin
            exp_vtype = {24'd0, raw[7:0]};
            exp_vl    = (longint'(avl) < vlmax) ? avl : 32'(vlmax);
        end else begin
            exp_vtype = VILL;
            exp_vl    = 32'd0;
        end
    endtask

    // Issue one instruction and check every cycle of its execution
    task automatic run_inst(input logic [1:0] kind, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [10:0] zi, input logic [4:0] ui, input logic r1x0,
                            input logic rdx0, input logic [31:0] cvl, input int stall);
        logic [31:0] ev, el;
        model(kind, rs1, rs2, zi, ui, r1x0, rdx0, cvl, ev, el);
        @(negedge clk);
        vset_kind = kind; rs1_data = rs1; rs2_data = rs2; zimm = zi; uimm = ui;
        rs1_is_x0 = r1x0; rd_is_x0 = rdx0; cur_vl = cvl;
        inst_valid = 1'b1; rd_ready = 1'b0;
        #1 check_val("ready_idle", {31'd0, inst_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble inputs: the unit must work from its captured copy
        inst_valid = 1'b0;
        vset_kind = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        zimm = 11'($urandom); uimm = 5'($urandom); cur_vl = $urandom;
        rs1_is_x0 = 1'($urandom); rd_is_x0 = 1'($urandom);
        check_val("decode_ready", {31'd0, inst_ready}, 32'd0);
        check_val("decode_csrwr", {31'd0, csrwr_en}, 32'd0);
        rd_ready = (stall == 0);
        @(posedge clk); #1;
        check_val("commit_csrwr", {31'd0, csrwr_en}, 32'd1);
        check_val("commit_vtype", vtype_o, ev);
        check_val("commit_vl", vl_o, el);
        check_val("commit_rd_data", rd_data, el);
        check_val("commit_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("post_csrwr", {31'd0, csrwr_en}, 32'd0);
        if (rdx0) begin
            check_val("x0_ready", {31'd0, inst_ready}, 32'd1);
            check_val("x0_rd_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
            check_val("resp_valid", {31'd0, rd_valid}, 32'd1);
            check_val("resp_data", rd_data, el);
            check_val("resp_ready", {31'd0, inst_ready}, 32'd0);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check_val("stall_valid", {31'd0, rd_valid}, 32'd1);
                check_val("stall_data", rd_data, el);
                check_val("stall_ready", {31'd0, inst_ready}, 32'd0);
            end
            rd_ready = 1'b1;
            @(posedge clk); #1;
            check_val("done_valid", {31'd0, rd_valid}, 32'd0);
            check_val("done_ready", {31'd0, inst_ready}, 32'd1);
        end
        check_val("hold_vl", vl_o, el);
        check_val("hold_vtype", vtype_o, ev);
        rd_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ready"}, {31'd0, inst_ready}, 32'd1);
        check_val({tag, "_csrwr"}, {31'd0, csrwr_en}, 32'd0);
        check_val({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check_val({tag, "_rd_data"}, rd_data, 32'd0);
        check_val({tag, "_vl"}, vl_o, 32'd0);
        check_val({tag, "_vtype"}, vtype_o, VILL);
    endtask

    initial begin
        int stall;
        logic [1:0] k;
        logic [10:0] zi;
        logic [31:0] r1, r2;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) n_rst = 1'b1;

        // Directed cases
        run_inst(2'd0, 32'd100, 32'd0, 11'h0D0, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd1, 32'd0, 32'd0, 11'h003, 5'd5, 1'b0, 1'b1, 32'd0, 0);
        run_inst(2'd0, 32'd0, 32'd0, 11'h01B, 5'd0, 1'b1, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'd0, 32'd0, 11'h01B, 5'd0, 1'b1, 1'b1, 32'd7, 0);
        run_inst(2'd2, 32'd50, 32'h20, 11'd0, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd2, 32'd50, 32'h104, 11'd0, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd3, 32'd50, 32'h0, 11'h0D0, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'd1000, 32'd0, 11'h007, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'd1000, 32'd0, 11'h00D, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'd0, 32'd0, 11'h0C0, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'hFFFF_FFFF, 32'd0, 11'h100, 5'd0, 1'b0, 1'b0, 32'd0, 0);
        run_inst(2'd0, 32'd300, 32'd0, 11'h012, 5'd0, 1'b0, 1'b0, 32'd0, 5);

        // Reset asserted while the instruction is in DECODE
        @(negedge clk);
        vset_kind = 2'd0; rs1_data = 32'd100; zimm = 11'h0D0;
        rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0; inst_valid = 1'b1; rd_ready = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        n_rst = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk) n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset_vals("after_rst");
        end
        rd_ready = 1'b0;

        // Randomized instructions
        for (int n = 0; n < 150; n++) begin
            k  = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
            zi = ($urandom_range(0, 7) == 0) ? 11'($urandom) : {3'd0, 8'($urandom)};
            r2 = ($urandom_range(0, 7) == 0) ? $urandom : {24'd0, 8'($urandom)};
            r1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_inst(k, r1, r2, zi, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, stall);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_vsetvl_unit.md
# vec_vsetvl_unit

Executes vsetvli/vsetivli/vsetvl for the vector co-processor. Accepts a decoded configuration instruction from the scalar-side dispatch, validates the requested vtype, and computes VLMAX and the new vl. It is the writer feeding the vector CSR register file (vtype/vl/write-enable). It returns the new vl to the scalar core for the rd writeback.

## Interface
- XLEN, 32, scalar/CSR data width.
- VLEN, 512, vector register length in bits (power of two, ≥ 64).
- ELEN, 64, maximum element width in bits.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- inst_valid  in  1  configuration instruction offered.
- inst_ready  out  1  block idle, can accept.
- vset_kind  in  2  00 vsetvli, 01 vsetivli, 10 vsetvl, 11 reserved (illegal).
- rs1_data  in  XLEN  AVL source for vsetvli/vsetvl.
- rs2_data  in  XLEN  vtype source for vsetvl.
- zimm  in  11  vtypei immediate (vsetvli 11 bits; vsetivli uses [9:0]).
- uimm  in  5  AVL immediate for vsetivli.
- rs1_is_x0  in  1  rs1 field is x0.
- rd_is_x0  in  1  rd field is x0.
- cur_vl  in  XLEN  current vl from CSR register file.
- csrwr_en  out  1  one-cycle CSR write strobe.
- vtype_o  out  XLEN  new vtype: [7] vma, [6] vta, [5:3] vsew, [2:0] vlmul, [XLEN-1] vill.
- vl_o  out  XLEN  new vl.
- rd_valid  out  1  rd writeback data valid.
- rd_ready  in  1  scalar core accepts rd data.
- rd_data  out  XLEN  new vl for rd.

## Operation
- States: IDLE → DECODE → COMMIT → RESP (or IDLE) → IDLE. inst_ready = (state == IDLE).
- IDLE: on inst_valid && inst_ready, register all inputs; go DECODE.
- DECODE: select raw vtype (vsetvl: rs2_data; vsetvli: zero-extended zimm; vsetivli: zero-extended zimm[9:0]). Legal iff vset_kind != 11, bits [XLEN-2:8] zero, vsew ≤ 3, vlmul ∈ {000,001,010,011} (plus fractional codes per Configuration), and SEW ≤ ELEN·LMUL. Compute VLMAX = (VLEN >> (3+vsew)) << vlmul (integer LMUL) or >> (8−vlmul) for fractional codes. Select AVL: vsetivli → uimm; else !rs1_is_x0 → rs1_data; else !rd_is_x0 → VLMAX; else → cur_vl. Go COMMIT.
- COMMIT: legal → vl = min(AVL, VLMAX) (unsigned XLEN compare), vtype_o = {0…, vtype[7:0]}; illegal → vtype_o = 1<<(XLEN-1), vl = 0. Drive vl_o, rd_data = vl, csrwr_en = 1. Next: rd_is_x0 → IDLE, else RESP.
- RESP: rd_valid = 1, rd_data stable until rd_valid && rd_ready, then IDLE.
- vtype_o, vl_o, rd_data hold last committed values outside COMMIT.

## Timing
- Accept at edge T; DECODE in cycle T+1; csrwr_en high only in cycle T+2 (CSR file latches at end of T+2); rd_valid first high in T+3.
- Throughput: one instruction per 3 cycles (rd=x0) or ≥ 4 cycles.
- rd_ready already high in T+3: rd_valid high exactly one cycle, IDLE in T+4.
- rd_ready low: hold RESP indefinitely, inputs ignored (inst_ready = 0).
- Reset values: state IDLE, inst_ready 1, csrwr_en 0, rd_valid 0, rd_data 0, vl_o 0, vtype_o = 1<<(XLEN-1).
- Reset asserted mid-operation: instruction discarded, no csrwr_en, no rd_valid.
- AVL = 0 legal: vl = 0, csrwr_en still pulses.

## Configuration
- VEC_FRACTIONAL_LMUL_EN defined: vlmul 101 (mf8), 110 (mf4), 111 (mf2) legal, subject to SEW ≤ ELEN·LMUL (mf8 SEW8 only, mf4 SEW ≤ 16, mf2 SEW ≤ 32); VLMAX = (VLEN >> (3+vsew)) >> (8−vlmul).
- Undefined: all of 100–111 illegal (vill set, vl = 0).
- 100 is illegal in both cases.

## Test plan
- vsetvli, rs1_data = 100, zimm = 0x0D0 (vma=1, vta=1, SEW32, LMUL1) → csrwr_en at T+2, vtype_o = 0xD0, vl_o = 16, rd_data = 16.
- vsetivli uimm = 5, zimm = 0x003 (SEW8, LMUL8) → vl_o = 5; rd_is_x0 = 1 → no rd_valid, inst_ready back at T+3.
- vsetvli rs1=x0, rd≠x0, zimm = 0x01B (SEW64, LMUL8) → vl_o = 64; rs1=x0, rd=x0, cur_vl = 7 → vl_o = 7.
- vsetvl rs2_data = 0x20 (vsew=4) or rs2_data = 0x104 (vlmul=100), or vset_kind = 11 → vtype_o = 0x80000000, vl_o = 0, rd_data = 0.
- vlmul = 111, SEW8: with VEC_FRACTIONAL_LMUL_EN, AVL = 1000 → vl_o = 32; without it → vill set. With it, vlmul = 101 + SEW16 → vill set.
- Hold rd_ready low 5 cycles then assert; and assert n_rst during DECODE → rd_valid held stable then single transfer; reset case produces no csrwr_en, outputs at reset values.
